// File: rtl/mc_pkg.sv
// mc_pkg
//   Shared definitions for the multicycle ARM-subset controller:
//   FSM state enum, Op field encodings, data-processing cmd encodings,
//   ALUControl encodings, condition-code constants and two small decode
//   helpers used by the controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Instr[24:21] (Funct[4:1]) for data-processing
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ALUControl
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // ALU operation for a data-processing cmd; unsupported cmds fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] ctl;
        case (cmd)
            CMD_ADD:          ctl = ALU_ADD;
            CMD_SUB, CMD_CMP: ctl = ALU_SUB;
            CMD_AND:          ctl = ALU_AND;
            CMD_ORR:          ctl = ALU_ORR;
            default:          ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // True for cmds that write a destination register (CMP and unsupported cmds do not).
    function automatic logic cmd_writes_rd(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check
//   Holds the NZCV flag register and evaluates the ARM condition field
//   against it.
//   Ports:
//     clk        in   clock
//     reset      in   asynchronous active-low reset (clears NZCV)
//     cond       in   [3:0] condition field Instr[31:28]
//     flag_load  in   request to capture alu_flags this cycle
//     alu_flags  in   [3:0] NZCV from the ALU
//     cond_ex    out  condition passes against the stored flags
module cond_check
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic       flag_load,
    input  logic [3:0] alu_flags,
    output logic       cond_ex
);

    logic [3:0] nzcv_reg;
    logic       n_flag, z_flag, c_flag, v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = nzcv_reg;

    // A flag-setting instruction that fails its own condition must not
    // update the flags, so the load is qualified by cond_ex.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzcv_reg <= 4'b0000;
        end else if (flag_load && cond_ex) begin
            nzcv_reg <= alu_flags;
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_flag;
            COND_NE: cond_ex = !z_flag;
            COND_CS: cond_ex = c_flag;
            COND_CC: cond_ex = !c_flag;
            COND_MI: cond_ex = n_flag;
            COND_PL: cond_ex = !n_flag;
            COND_VS: cond_ex = v_flag;
            COND_VC: cond_ex = !v_flag;
            COND_HI: cond_ex = c_flag && !z_flag;
            COND_LS: cond_ex = !c_flag || z_flag;
            COND_GE: cond_ex = (n_flag == v_flag);
            COND_LT: cond_ex = (n_flag != v_flag);
            COND_GT: cond_ex = !z_flag && (n_flag == v_flag);
            COND_LE: cond_ex = z_flag || (n_flag != v_flag);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;    // NV
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
//   Multicycle ARM-subset control unit: ten-state FSM producing the datapath
//   controls for fetch, decode, load/store, data-processing and branch.
//   Optional feature: define MC_CTRL_PERF_EN to add the retired-instruction
//   counter and its InstrCount output port.
//   Ports:
//     clk         in   clock
//     reset       in   asynchronous active-low reset
//     Cond        in   [3:0] Instr[31:28]
//     Op          in   [1:0] Instr[27:26]
//     Funct       in   [5:0] Instr[25:20]  {I, cmd[3:0], S/L}
//     Rd          in   [3:0] Instr[15:12]
//     ALUFlags    in   [3:0] NZCV from the ALU
//     MemReady    in   memory access completes this cycle
//     PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA   out 1 bit
//     ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc          out 2 bits
//     InstrCount  out  [CNT_W-1:0] retired instructions (MC_CTRL_PERF_EN only)
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic [3:0]       ALUFlags,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] InstrCount
`endif
);

    generate
        if (CNT_W < 1) begin : g_cnt_w_check
            $error("mc_controller: CNT_W must be at least 1");
        end
    endgenerate

    state_t     state_reg, state_next;
    logic       cond_ex;
    logic       flag_load;
    logic [3:0] cmd;
    logic       funct_i, funct_sl;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;

    assign cmd      = Funct[4:1];
    assign funct_i  = Funct[5];
    assign funct_sl = Funct[0];

    // Flags are captured on the edge leaving ALUWB for S-suffixed ops and CMP.
    assign flag_load = (state_reg == S_ALUWB) && (funct_sl || (cmd == CMD_CMP));

    cond_check u_cond_check (
        .clk       (clk),
        .reset     (reset),
        .cond      (Cond),
        .flag_load (flag_load),
        .alu_flags (ALUFlags),
        .cond_ex   (cond_ex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        result_src  = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = 2'b00;
        reg_src     = 2'b00;

        case (state_reg)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // Instruction latch and PC+4 only once the fetch data is valid.
                ir_write   = MemReady;
                pc_write   = MemReady;
                if (MemReady) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_BR:   state_next = S_BRANCH;
                    OP_DP:   state_next = funct_i ? S_EXECI : S_EXECR;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b   = 2'b01;
                imm_src     = 2'b01;
                alu_control = ALU_ADD;
                state_next  = funct_sl ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (MemReady) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                // Held for the whole access, not just the completing cycle.
                mem_write = cond_ex;
                if (MemReady) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_b   = 2'b00;
                alu_control = alu_decode(cmd);
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b   = 2'b01;
                imm_src     = 2'b00;
                alu_control = alu_decode(cmd);
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src  = 2'b00;
                alu_control = alu_decode(cmd);
                reg_write   = cond_ex && cmd_writes_rd(cmd);
                // Writing R15 is a jump: the result goes to the PC as well.
                pc_write    = cond_ex && cmd_writes_rd(cmd) && (Rd == 4'hF);
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write   = cond_ex;
                reg_src[0] = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Stores read Rd as the data register; the latched instruction is
        // only meaningful once FETCH has completed.
        if ((state_reg != S_FETCH) && (Op == OP_MEM) && !funct_sl) begin
            reg_src[1] = 1'b1;
        end
    end

    // The FSM sits in FETCH during reset, where the enables would otherwise
    // follow MemReady; reset masks every write strobe.
    assign PCWrite    = pc_write  & reset;
    assign IRWrite    = ir_write  & reset;
    assign MemWrite   = mem_write & reset;
    assign RegWrite   = reg_write & reset;
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ResultSrc  = result_src;
    assign ALUSrcB    = alu_src_b;
    assign ALUControl = alu_control;
    assign ImmSrc     = imm_src;
    assign RegSrc     = reg_src;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] count_reg;

    // An instruction retires whenever the FSM re-enters FETCH; waiting in
    // FETCH for MemReady does not count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if ((state_reg != S_FETCH) && (state_next == S_FETCH)) begin
            count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign InstrCount = count_reg;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
//   Self-checking bench for mc_controller. Each instruction is expanded into
//   its expected cycle sequence from its class (DP / memory / branch / undefined),
//   memory wait counts and condition outcome; every cycle's full output word is
//   compared against the expectation. Flag state and retired count are tracked
//   at instruction level. Define MC_CTRL_PERF_EN to also check InstrCount on a
//   32-bit and a 4-bit counter instance.
module tb_mc_controller;

    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_MEMADR = 2;
    localparam int P_MEMRD  = 3;
    localparam int P_MEMWB  = 4;
    localparam int P_MEMWR  = 5;
    localparam int P_EXECR  = 6;
    localparam int P_EXECI  = 7;
    localparam int P_ALUWB  = 8;
    localparam int P_BRANCH = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [15:0] got_v;

    int         checks   = 0;
    int         failures = 0;
    int         instr_no = 0;
    logic [3:0] nzcv_m;
    int         count_m;

    always #5 clk = ~clk;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] InstrCount;
    logic [3:0]  InstrCount4;
    logic        pcw4, adr4, mw4, irw4, rw4, asa4;
    logic [1:0]  rs4, asb4, ac4, is4, rgs4;

    mc_controller #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(pcw4), .AdrSrc(adr4), .MemWrite(mw4), .IRWrite(irw4),
        .RegWrite(rw4), .ALUSrcA(asa4), .ResultSrc(rs4), .ALUSrcB(asb4),
        .ALUControl(ac4), .ImmSrc(is4), .RegSrc(rgs4), .InstrCount(InstrCount4)
    );
`endif

    mc_controller #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ResultSrc(ResultSrc),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc)
`ifdef MC_CTRL_PERF_EN
        , .InstrCount(InstrCount)
`endif
    );

    assign got_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
                    ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic string pname(input int ph);
        case (ph)
            P_FETCH:  return "FETCH";
            P_DECODE: return "DECODE";
            P_MEMADR: return "MEMADR";
            P_MEMRD:  return "MEMRD";
            P_MEMWB:  return "MEMWB";
            P_MEMWR:  return "MEMWR";
            P_EXECR:  return "EXECR";
            P_EXECI:  return "EXECI";
            P_ALUWB:  return "ALUWB";
            default:  return "BRANCH";
        endcase
    endfunction

    // ARM condition rule: even codes test a predicate, odd codes its inverse;
    // 1110 always, 1111 never.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? ~r : r;
    endfunction

    function automatic logic [1:0] alu_op(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b1010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [3:0] cmd);
        return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100;
    endfunction

    // Expected output word for a phase of the current instruction.
    function automatic logic [15:0] expv(input int ph, input logic mr, input logic ce);
        logic pcw, adr, mw, irw, rw, asa;
        logic [1:0] rs, asb, ac, is, rgs;
        logic [3:0] cmd;
        cmd = Funct[4:1];
        {pcw, adr, mw, irw, rw, asa} = 6'b0;
        {rs, asb, ac, is, rgs} = 10'b0;
        case (ph)
            P_FETCH:  begin asa = 1; asb = 2; rs = 2; irw = mr; pcw = mr; end
            P_DECODE: begin asa = 1; asb = 2; rs = 2; end
            P_MEMADR: begin asb = 1; is = 1; end
            P_MEMRD:  adr = 1;
            P_MEMWB:  begin rs = 1; rw = ce; end
            P_MEMWR:  begin adr = 1; mw = ce; end
            P_EXECR:  ac = alu_op(cmd);
            P_EXECI:  begin asb = 1; ac = alu_op(cmd); end
            P_ALUWB:  begin
                ac  = alu_op(cmd);
                rw  = ce && writes_rd(cmd);
                pcw = rw && (Rd == 4'd15);
            end
            default:  begin asb = 1; is = 2; rs = 2; pcw = ce; rgs[0] = 1; end
        endcase
        if (ph != P_FETCH && Op == 2'b01 && !Funct[0]) rgs[1] = 1;
        return {pcw, adr, mw, irw, rw, asa, rs, asb, ac, is, rgs};
    endfunction

    task automatic cyc(input string name, input int ph, input logic mr, input logic ce,
                       input logic [3:0] flags);
        MemReady = mr;
        ALUFlags = (ph == P_ALUWB) ? flags : 4'($urandom);
        #1;
        chk($sformatf("%s/%s", name, pname(ph)), 32'(got_v), 32'(expv(ph, mr, ce)));
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string name);
`ifdef MC_CTRL_PERF_EN
        chk($sformatf("%s/InstrCount", name), InstrCount, 32'(count_m));
        chk($sformatf("%s/InstrCount4", name), 32'(InstrCount4), 32'(count_m % 16));
`else
        if (name.len() < 0) chk(name, 32'(count_m), 32'd0);
`endif
    endtask

    task automatic run_instr(input string name, input logic [3:0] cond, input logic [1:0] op,
                             input logic [5:0] funct, input logic [3:0] rd,
                             input logic [3:0] flags, input int fwait, input int mwait);
        logic ce;
        ce    = cond_pass(cond, nzcv_m);
        Cond  = cond;
        Op    = op;
        Funct = funct;
        Rd    = rd;
        check_count(name);
        for (int i = 0; i <= fwait; i++) cyc(name, P_FETCH, i == fwait, ce, flags);
        cyc(name, P_DECODE, 1'($urandom), ce, flags);
        case (op)
            2'b01: begin
                cyc(name, P_MEMADR, 1'($urandom), ce, flags);
                if (funct[0]) begin
                    for (int i = 0; i <= mwait; i++) cyc(name, P_MEMRD, i == mwait, ce, flags);
                    cyc(name, P_MEMWB, 1'($urandom), ce, flags);
                end else begin
                    for (int i = 0; i <= mwait; i++) cyc(name, P_MEMWR, i == mwait, ce, flags);
                end
            end
            2'b10: cyc(name, P_BRANCH, 1'($urandom), ce, flags);
            2'b00: begin
                cyc(name, funct[5] ? P_EXECI : P_EXECR, 1'($urandom), ce, flags);
                cyc(name, P_ALUWB, 1'($urandom), ce, flags);
                if (ce && (funct[0] || funct[4:1] == 4'b1010)) nzcv_m = flags;
            end
            default: ;
        endcase
        count_m++;
        instr_no++;
        $display("instr %0d %s cond=%h op=%0d funct=%b rd=%0d condex=%0b nzcv=%b",
                 instr_no, name, cond, op, funct, rd, ce, nzcv_m);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] cmds [6];
        logic [3:0] rc;
        logic [1:0] rop;
        int         r;
        cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b1100, 4'b0111};

        reset = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'b0; Rd = 4'd0;
        ALUFlags = 4'b0; MemReady = 1'b1;
        nzcv_m = 4'b0; count_m = 0;

        // Reset state: FETCH controls with all write strobes masked.
        @(posedge clk); #1;
        chk("reset/fetch_mr1", 32'(got_v), 32'(expv(P_FETCH, 1'b0, 1'b0)));
        MemReady = 1'b0;
        @(posedge clk); #1;
        chk("reset/fetch_mr0", 32'(got_v), 32'(expv(P_FETCH, 1'b0, 1'b0)));
        reset = 1'b1;

        run_instr("add_r1", 4'hE, 2'b00, 6'b0_0100_0, 4'd1, 4'b0000, 1, 0);
        run_instr("ldr_wait3", 4'hE, 2'b01, 6'b0_1100_1, 4'd2, 4'b0000, 0, 3);
        run_instr("subs_z", 4'hE, 2'b00, 6'b0_0010_1, 4'd3, 4'b0100, 0, 0);
        run_instr("beq_taken", 4'h0, 2'b10, 6'b10_0000, 4'd0, 4'b0000, 0, 0);
        run_instr("bne_not", 4'h1, 2'b10, 6'b10_0000, 4'd0, 4'b0000, 0, 0);
        run_instr("str_never", 4'hF, 2'b01, 6'b0_1100_0, 4'd4, 4'b0000, 0, 2);

        // Reset in the middle of a held store.
        Cond = 4'hE; Op = 2'b01; Funct = 6'b0_1100_0; Rd = 4'd5;
        cyc("str_rst", P_FETCH, 1'b1, 1'b1, 4'b0);
        cyc("str_rst", P_DECODE, 1'b0, 1'b1, 4'b0);
        cyc("str_rst", P_MEMADR, 1'b0, 1'b1, 4'b0);
        MemReady = 1'b0; #1;
        chk("str_rst/MEMWR", 32'(got_v), 32'(expv(P_MEMWR, 1'b0, 1'b1)));
        reset = 1'b0; MemReady = 1'b1; #1;
        chk("str_rst/in_reset", 32'(got_v), 32'(expv(P_FETCH, 1'b0, 1'b0)));
        @(posedge clk); #1;
        chk("str_rst/held", 32'(got_v), 32'(expv(P_FETCH, 1'b0, 1'b0)));
        reset = 1'b1;
        nzcv_m = 4'b0; count_m = 0;

        // Flags cleared by reset: EQ fails, NE passes.
        run_instr("beq_after_rst", 4'h0, 2'b10, 6'b10_0000, 4'd0, 4'b0000, 0, 0);
        run_instr("bne_after_rst", 4'h1, 2'b10, 6'b10_0000, 4'd0, 4'b0000, 0, 0);
        for (int i = 0; i < 15; i++)
            run_instr("add_seq", 4'hE, 2'b00, 6'b0_0100_0, 4'(i), 4'b0000, 0, 0);
        check_count("after17");
        run_instr("undef_op", 4'hE, 2'b11, 6'b00_0000, 4'd0, 4'b0000, 0, 0);
        run_instr("cmp_pc", 4'hE, 2'b00, 6'b1_1010_0, 4'd15, 4'b1001, 0, 0);
        run_instr("add_pc", 4'hE, 2'b00, 6'b1_0100_0, 4'd15, 4'b0000, 0, 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      rop = 2'b00;
            else if (r < 8) rop = 2'b01;
            else if (r < 9) rop = 2'b10;
            else            rop = 2'b11;
            rc = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            run_instr("rand", rc, rop,
                      {1'($urandom), cmds[$urandom_range(0, 5)], 1'($urandom)},
                      4'($urandom), 4'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end
        check_count("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
